// File: rtl/buaa_seq_ctrl.sv
// Animation sequencer for the BUAA seven-segment stage: fills the segments one by one,
// blinks the full display BLINKS times, then leaves it fully lit.
//
// state | meaning
// IDLE  | waiting for start; ctrl[7:0] holds its last value
// FILL  | one more segment lit per prescaler tick (80, C0 ... FF)
// BLINK | ctrl[7:0] toggles 00/FF per tick, ending on FF
module buaa_seq_ctrl #(
    parameter int DIV    = 50_000_000,
    parameter int BLINKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    output logic [8:0] ctrl,
    output logic       busy,
    output logic       done
);

    localparam int PW = $clog2(DIV);
    localparam int BW = $clog2(2 * BLINKS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] BLINK = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] pcnt;
    logic [2:0]    step;
    logic [BW-1:0] bcnt;
    logic          tick;

    assign tick = (pcnt == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pcnt  <= '0;
            step  <= '0;
            bcnt  <= '0;
            ctrl  <= 9'h000;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !pause) begin
                        state <= FILL;
                        busy  <= 1'b1;
                        ctrl  <= 9'h100;
                        pcnt  <= '0;
                        step  <= '0;
                    end
                end
                FILL: begin
                    // Pause freezes everything, including the prescaler phase.
                    if (!pause) begin
                        if (tick) begin
                            pcnt      <= '0;
                            ctrl[7:0] <= {1'b1, ctrl[7:1]};
                            step      <= step + 3'd1;
                            if (step == 3'd7) begin
                                state <= BLINK;
                                bcnt  <= '0;
                            end
                        end else begin
                            pcnt <= pcnt + PW'(1);
                        end
                    end
                end
                BLINK: begin
                    if (!pause) begin
                        if (tick) begin
                            pcnt      <= '0;
                            ctrl[7:0] <= ~ctrl[7:0];
                            bcnt      <= bcnt + BW'(1);
                            // Last toggle lands on FF, which IDLE then keeps.
                            if (bcnt == BW'(2 * BLINKS - 1)) begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                ctrl[8] <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            pcnt <= pcnt + PW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buaa_seq_ctrl.sv
// Self-checking bench for buaa_seq_ctrl (DIV=4, BLINKS=2) against a cycle-count
// reference model of the animation timeline.
module tb_buaa_seq_ctrl;

    localparam int DIV    = 4;
    localparam int BLINKS = 2;
    localparam int TOTAL  = DIV * (8 + 2 * BLINKS);

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic [8:0] ctrl;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    buaa_seq_ctrl #(.DIV(DIV), .BLINKS(BLINKS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .pause (pause),
        .ctrl  (ctrl),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: elapsed un-paused cycles since acceptance determine the display.
    bit         m_active;
    int         m_e;
    logic [7:0] m_last;
    bit         m_done;

    function automatic logic [7:0] pattern(input int k);
        logic [7:0] ff;
        ff = 8'hFF;
        if (k < 8) return ~(ff >> k);
        return ((k - 8) % 2 == 1) ? 8'h00 : 8'hFF;
    endfunction

    function automatic logic [8:0] exp_ctrl();
        if (m_active) return {1'b1, pattern(m_e / DIV)};
        return {1'b0, m_last};
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_e      = 0;
        m_last   = 8'h00;
        m_done   = 0;
    endtask

    task automatic model_edge(input logic s, input logic p);
        m_done = 0;
        if (!m_active) begin
            if (s && !p) begin
                m_active = 1;
                m_e      = 0;
            end
        end else if (!p) begin
            m_e++;
            if (m_e == TOTAL) begin
                m_active = 0;
                m_done   = 1;
                m_last   = 8'hFF;
            end
        end
    endtask

    task automatic drive_cycle(input logic s, input logic p);
        start = s;
        pause = p;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(s, p);
        #1;
    endtask

    task automatic apply_reset();
        start = 1'b0;
        pause = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({ctrl, busy, done} !== {9'h000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got ctrl=%h busy=%b done=%b, want 000/0/0", ctrl, busy, done);
        end
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, 1'b0);
            n_vec++;
            if ({ctrl, busy, done} !== {exp_ctrl(), m_active, m_done}) begin
                n_err++;
                $display("FAIL idle_hold cyc%0d: got ctrl=%h busy=%b done=%b, want ctrl=%h busy=%b done=%b",
                         i, ctrl, busy, done, exp_ctrl(), m_active, m_done);
            end
        end
    endtask

    task automatic test_nominal();
        logic [10:0] want;
        apply_reset();
        drive_cycle(1'b1, 1'b0);
        n_vec++;
        if ({ctrl, busy} !== {9'h100, 1'b1}) begin
            n_err++;
            $display("FAIL nominal_accept: got ctrl=%h busy=%b, want 100/1", ctrl, busy);
        end
        for (int i = 1; i <= 50; i++) begin
            drive_cycle(1'b0, 1'b0);
            n_vec++;
            if ({ctrl, busy, done} !== {exp_ctrl(), m_active, m_done}) begin
                n_err++;
                $display("FAIL nominal_model t0+%0d: got ctrl=%h busy=%b done=%b, want ctrl=%h busy=%b done=%b",
                         i, ctrl, busy, done, exp_ctrl(), m_active, m_done);
            end
            want = 11'h7FF;
            case (i)
                4:  want = {9'h180, 2'b10};
                8:  want = {9'h1C0, 2'b10};
                32: want = {9'h1FF, 2'b10};
                36: want = {9'h100, 2'b10};
                40: want = {9'h1FF, 2'b10};
                44: want = {9'h100, 2'b10};
                48: want = {9'h0FF, 2'b01};
                49: want = {9'h0FF, 2'b00};
                default: ;
            endcase
            if (want != 11'h7FF) begin
                n_vec++;
                if ({ctrl, busy, done} !== want) begin
                    n_err++;
                    $display("FAIL nominal_timeline t0+%0d: got ctrl=%h busy=%b done=%b, want %h/%b/%b",
                             i, ctrl, busy, done, want[10:2], want[1], want[0]);
                end
            end
        end
    endtask

    task automatic test_pause();
        logic s, p;
        apply_reset();
        drive_cycle(1'b1, 1'b0);
        for (int i = 1; i <= 56; i++) begin
            p = (i >= 10 && i <= 14);
            s = (i < 50) && ((i % 7) == 3);
            drive_cycle(s, p);
            n_vec++;
            if ({ctrl, busy, done} !== {exp_ctrl(), m_active, m_done}) begin
                n_err++;
                $display("FAIL pause_model t0+%0d: got ctrl=%h busy=%b done=%b, want ctrl=%h busy=%b done=%b",
                         i, ctrl, busy, done, exp_ctrl(), m_active, m_done);
            end
            if (i == 53) begin
                n_vec++;
                if ({ctrl, busy, done} !== {9'h0FF, 1'b0, 1'b1}) begin
                    n_err++;
                    $display("FAIL pause_completion: got ctrl=%h busy=%b done=%b, want 0FF/0/1", ctrl, busy, done);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive_cycle(1'b1, 1'b0);
        for (int i = 1; i < 20; i++) drive_cycle(1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({ctrl, busy, done} !== {9'h000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset_immediate: got ctrl=%h busy=%b done=%b, want 000/0/0", ctrl, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 1'b0);
        for (int i = 1; i <= 50; i++) begin
            drive_cycle(1'b0, 1'b0);
            n_vec++;
            if ({ctrl, busy, done} !== {exp_ctrl(), m_active, m_done}) begin
                n_err++;
                $display("FAIL after_reset_model t0+%0d: got ctrl=%h busy=%b done=%b, want ctrl=%h busy=%b done=%b",
                         i, ctrl, busy, done, exp_ctrl(), m_active, m_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int low_cycles;
        low_cycles = 0;
        apply_reset();
        drive_cycle(1'b1, 1'b0);
        for (int i = 1; i < 110; i++) begin
            drive_cycle(1'b1, 1'b0);
            if (!busy) low_cycles++;
            n_vec++;
            if ({ctrl, busy, done} !== {exp_ctrl(), m_active, m_done}) begin
                n_err++;
                $display("FAIL b2b_model t0+%0d: got ctrl=%h busy=%b done=%b, want ctrl=%h busy=%b done=%b",
                         i, ctrl, busy, done, exp_ctrl(), m_active, m_done);
            end
            if (i == 49) begin
                n_vec++;
                if ({ctrl, busy} !== {9'h100, 1'b1}) begin
                    n_err++;
                    $display("FAIL b2b_restart: got ctrl=%h busy=%b, want 100/1", ctrl, busy);
                end
            end
        end
        n_vec++;
        if (low_cycles != 2) begin
            n_err++;
            $display("FAIL b2b_busy_gap: got %0d idle cycles, want 2", low_cycles);
        end
    endtask

    task automatic test_start_with_pause();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b1);
            n_vec++;
            if ({ctrl, busy} !== {9'h000, 1'b0}) begin
                n_err++;
                $display("FAIL start_paused_ignored cyc%0d: got ctrl=%h busy=%b, want 000/0", i, ctrl, busy);
            end
        end
        drive_cycle(1'b1, 1'b0);
        n_vec++;
        if ({ctrl, busy} !== {9'h100, 1'b1}) begin
            n_err++;
            $display("FAIL start_unpaused_accept: got ctrl=%h busy=%b, want 100/1", ctrl, busy);
        end
        for (int i = 1; i <= 50; i++) begin
            drive_cycle(1'b0, 1'b0);
            n_vec++;
            if ({ctrl, busy, done} !== {exp_ctrl(), m_active, m_done}) begin
                n_err++;
                $display("FAIL unpause_model t0+%0d: got ctrl=%h busy=%b done=%b, want ctrl=%h busy=%b done=%b",
                         i, ctrl, busy, done, exp_ctrl(), m_active, m_done);
            end
        end
    endtask

    task automatic test_random();
        logic s, p;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 5) == 0);
            drive_cycle(s, p);
            n_vec++;
            if ({ctrl, busy, done} !== {exp_ctrl(), m_active, m_done}) begin
                n_err++;
                $display("FAIL random_model cyc%0d: got ctrl=%h busy=%b done=%b, want ctrl=%h busy=%b done=%b",
                         i, ctrl, busy, done, exp_ctrl(), m_active, m_done);
            end
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                n_vec++;
                if ({ctrl, busy, done} !== {9'h000, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL random_reset cyc%0d: got ctrl=%h busy=%b done=%b, want 000/0/0",
                             i, ctrl, busy, done);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        model_reset();
        test_reset();
        test_nominal();
        test_pause();
        test_async_reset();
        test_back_to_back();
        test_start_with_pause();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/buaa_seq_ctrl.md
# buaa_seq_ctrl

Timed animation sequencer that generates the 9-bit `ctrl` word consumed by the BUAA seven-segment display stage. Each segment lights in turn at a programmable step rate, then the whole display blinks a set number of times and is left fully lit. The block sits directly upstream of the display decoder. Its `ctrl[7:0]` bits map one-to-one onto display positions dev0..dev7 (`ctrl[7]`→dev0 … `ctrl[0]`→dev7). `ctrl[8]` is a "sequence active" flag that the display stage ignores.

## Interface
- `DIV`, default 50_000_000 — clock cycles per animation step; legal range ≥ 2.
- `BLINKS`, default 3 — number of off/on blink pairs after fill; legal range ≥ 1.
- `clk` input 1 — system clock; all state changes on the rising edge.
- `rst_n` input 1 — asynchronous, active-low reset; one clock domain only.
- `start` input 1 — request a sequence; sampled each rising edge.
- `pause` input 1 — level; freezes the sequence while high.
- `ctrl` output 9 — to the display stage; `[7:0]` segment enables, `[8]` active flag.
- `busy` output 1 — high while in FILL or BLINK.
- `done` output 1 — one-cycle pulse when the sequence completes.

## Operation
- States: IDLE, FILL, BLINK.
- Prescaler `pcnt` counts 0..DIV-1, width $clog2(DIV). It runs only in FILL and BLINK with `pause` low. `tick` = (`pcnt`==DIV-1); `pcnt` wraps to 0 on tick.
- IDLE:
  - `start`=1 and `pause`=0 → FILL, with `ctrl`←9'h100, `pcnt`←0, step←0.
  - `start` while `pause`=1 is ignored.
  - IDLE holds the last `ctrl[7:0]` value: 8'h00 after reset, 8'hFF after a completed sequence.
- FILL:
  - Each tick: `ctrl[7:0]` ← (`ctrl[7:0]`>>1) | 8'h80, giving 80, C0, E0 … FF.
  - The 8th tick (`ctrl[7:0]`=FF) → BLINK, blink counter←0.
- BLINK:
  - Each tick toggles `ctrl[7:0]` between FF and 00, starting with 00. Blink counter increments; its width holds 2*BLINKS.
  - The tick that completes toggle 2*BLINKS (value FF) → IDLE, with `ctrl[8]`←0 and `done`←1 in the same cycle.
- `start` in FILL or BLINK is ignored; there is no restart.
- `pause` high in FILL or BLINK holds `pcnt`, state, and `ctrl` exactly. Resuming continues from the held `pcnt`, so no step is lost or added.
- `busy` = (state≠IDLE), registered together with the state.

## Timing
- Reset values (asynchronous, immediate, valid mid-sequence): state=IDLE, `ctrl`=9'h000, `busy`=0, `done`=0, `pcnt`=0, all counters 0.
- Cycle numbering below is relative to edge t0, where `start` is accepted.
  - After t0: `ctrl`=9'h100, `busy`=1.
  - First update is at edge t0+DIV. Fill step k (1..8) is at t0+k·DIV.
  - Blink toggle j (1..2·BLINKS) is at t0+(8+j)·DIV.
- Completion is at edge t0+DIV·(8+2·BLINKS), with `ctrl`=9'h0FF, `busy`=0, `done`=1.
  - `done` drops on the following edge.
  - A `start` high in that following cycle is accepted, giving back-to-back sequences.
- Each paused cycle delays all later events by exactly one cycle.
- Outputs are registered; there is no combinational path from `start` or `pause` to `ctrl`.

## Test plan
All scenarios use DIV=4, BLINKS=2.
- Reset → `ctrl`=000, `busy`=0, `done`=0. Hold `start`=0 for 20 cycles → nothing changes.
- `start` 1-cycle pulse at t0 → `ctrl`=100 after t0; 180 at t0+4; 1C0 at t0+8; 1FF at t0+32; 100 at t0+36; 1FF at t0+40; 100 at t0+44; 0FF with `done`=1 and `busy`=0 at t0+48; `done`=0 at t0+49.
- `pause` high for 5 cycles starting at t0+10 → every later event shifts by exactly 5 cycles; completion at t0+53. `start` pulses during the sequence have no effect.
- `rst_n` low at t0+20 (asynchronous, between edges) → outputs go to 000/0/0 immediately. After release, the block is in IDLE and a new `start` gives the nominal timing.
- `start` held high continuously → a new sequence is accepted the cycle after `done`. `ctrl` goes 0FF→100 and `busy` is low for exactly one cycle.
- `start`=1 together with `pause`=1 in IDLE → ignored. Dropping `pause` with `start` still high → accepted on that edge.
